uart_rx_stream: RTL

UART_RX_STREAM -- requirements
Module: uart_rx_stream

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_stream.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame width
// and the parity helper used by the UART_RX_PARITY_EN build.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Even-parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset
// to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= i_async;
      sync_r <= meta_r;
    end
  end

  assign o_sync = sync_r;

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// one-deep AXI-Stream-style output register and error pulses.
module uart_rx_stream
  import uart_rx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 278,
  parameter logic [7:0]  TLAST_CHAR   = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t      state_r, state_next_s;
  logic           rx_s, rx_prev_r, fall_s, cnt_zero_s;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r, tdata_r;
  logic           par_bad_r, stop_seen_r, parity_bad_s;
  logic           sample_stop_s, byte_ok_s, frame_err_s;
  logic           tlast_r, tvalid_r, frame_err_r, overrun_r;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_uart_rx),
    .o_sync  (rx_s)
  );

  assign fall_s     = rx_prev_r & ~rx_s;
  assign cnt_zero_s = (clk_cnt_r == {CNT_W{1'b0}});

`ifdef UART_RX_PARITY_EN
  assign parity_bad_s = (even_parity(shift_r) != rx_s);
`else
  assign parity_bad_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:   if (fall_s) state_next_s = START; else state_next_s = IDLE;
      START: begin
        if (cnt_zero_s) state_next_s = rx_s ? IDLE : DATA;
        else            state_next_s = START;
      end
      DATA: begin
        if (cnt_zero_s && (bit_cnt_r == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_next_s = PARITY;
`else
          state_next_s = STOP;
`endif
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: if (cnt_zero_s) state_next_s = STOP; else state_next_s = PARITY;
      // A low stop bit parks here until the line idles, so a break cannot retrigger.
      STOP:   if ((cnt_zero_s || stop_seen_r) && rx_s) state_next_s = IDLE; else state_next_s = STOP;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: per-frame completion and error strobes.
  always_comb begin
    sample_stop_s = 1'b0;
    case (state_r)
      STOP:    sample_stop_s = cnt_zero_s && !stop_seen_r;
      default: sample_stop_s = 1'b0;
    endcase
    // A parity failure already reported this frame suppresses the framing pulse.
    byte_ok_s   = sample_stop_s && rx_s && !par_bad_r;
    frame_err_s = sample_stop_s && !rx_s && !par_bad_r;
  end

  // Bit timing, data shift register and per-frame status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_prev_r   <= 1'b1;
      clk_cnt_r   <= {CNT_W{1'b0}};
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_bad_r   <= 1'b0;
      stop_seen_r <= 1'b0;
    end else begin
      rx_prev_r <= rx_s;
      case (state_r)
        IDLE: begin
          clk_cnt_r   <= CNT_HALF;
          bit_cnt_r   <= 3'd0;
          par_bad_r   <= 1'b0;
          stop_seen_r <= 1'b0;
        end
        START: clk_cnt_r <= cnt_zero_s ? CNT_FULL : clk_cnt_r - 1'b1;
        DATA: begin
          if (cnt_zero_s) begin
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            clk_cnt_r <= CNT_FULL;
          end else begin
            clk_cnt_r <= clk_cnt_r - 1'b1;
          end
        end
        PARITY: begin
          if (cnt_zero_s) begin
            par_bad_r <= parity_bad_s;
            clk_cnt_r <= CNT_FULL;
          end else begin
            clk_cnt_r <= clk_cnt_r - 1'b1;
          end
        end
        STOP: begin
          if (cnt_zero_s) stop_seen_r <= 1'b1;
          else            clk_cnt_r   <= clk_cnt_r - 1'b1;
        end
        default: clk_cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Output beat register with overrun detection; a same-cycle accept frees the slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tdata_r     <= 8'h00;
      tlast_r     <= 1'b0;
      tvalid_r    <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= frame_err_s;
      overrun_r   <= 1'b0;
      if (byte_ok_s) begin
        if (!tvalid_r || i_tready) begin
          tdata_r  <= shift_r;
          tlast_r  <= (shift_r == TLAST_CHAR);
          tvalid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (tvalid_r && i_tready) begin
        tvalid_r <= 1'b0;
      end else begin
        tvalid_r <= tvalid_r;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_r;

  // Parity mismatch strobe, registered like the other error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_err_r <= 1'b0;
    else          parity_err_r <= (state_r == PARITY) && cnt_zero_s && parity_bad_s;
  end
  assign o_parity_err = parity_err_r;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_tdata     = tdata_r;
  assign o_tlast     = tlast_r;
  assign o_tvalid    = tvalid_r;
  assign o_frame_err = frame_err_r;
  assign o_overrun   = overrun_r;

endmodule
